// File: rtl/wb_pkg.sv
// Shared constants and beat layout for the write-back select stage.
package wb_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RD_W     = 5;

  // Conventional source indices for the default 4-source configuration.
  localparam int unsigned SEL_MEM = 0;
  localparam int unsigned SEL_ALU = 1;
  localparam int unsigned SEL_PC4 = 2;
  localparam int unsigned SEL_CSR = 3;

  // Sideband that travels with the selected data.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            wen;
    logic            sel_err;
  } wb_meta_t;

  // Full beat at the default datapath width.
  typedef struct packed {
    logic [XLEN_DEF-1:0] data;
    wb_meta_t            meta;
  } wb_beat_t;

  // Width of a packed {data, meta} beat for an arbitrary datapath width.
  function automatic int unsigned beat_width(input int unsigned xlen);
    return xlen + $bits(wb_meta_t);
  endfunction

endpackage

// File: rtl/wb_select_pipe_skid.sv
// Two-entry valid/ready buffer; ready is registered so it never depends on out_ready_i.
module wb_select_pipe_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_ONE   = 2'd1;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop;

  assign push        = in_valid_i & in_ready_q;
  assign out_valid_o = (count_q != CNT_EMPTY);
  assign pop         = out_valid_o & out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = head_q;

  // Occupancy transitions; head always holds the oldest beat.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      CNT_EMPTY: begin
        if (push) begin
          head_d  = in_data_i;
          count_d = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (push && pop) begin
          head_d = in_data_i;
        end else if (push) begin
          tail_d  = in_data_i;
          count_d = CNT_FULL;
        end else if (pop) begin
          count_d = CNT_EMPTY;
        end
      end
      CNT_FULL: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = CNT_ONE;
        end
      end
      default: count_d = CNT_EMPTY;
    endcase
    in_ready_d = (count_d != CNT_FULL);
  end

  // All buffer state, synchronously cleared; in-flight beats are dropped on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= CNT_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/wb_select_pipe.sv
// Write-back select stage: picks one of NSRC results, qualifies wen, buffers behind valid/ready.
module wb_select_pipe
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NSRC = 4,
  parameter int unsigned SELW = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [NSRC*XLEN-1:0] io_srcs,
  input  logic [SELW-1:0]    io_sel,
  input  logic [RD_W-1:0]    io_rd,
  input  logic               io_wen,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [XLEN-1:0]    io_out_data,
  output logic [RD_W-1:0]    io_out_rd,
  output logic               io_out_wen,
  output logic               io_sel_err
);

  localparam int unsigned BeatW = beat_width(XLEN);

  int unsigned      sel_idx;
  logic [XLEN-1:0]  sel_data;
  logic             sel_err;
  wb_meta_t         meta_in, meta_out;
  logic [BeatW-1:0] beat_in, beat_out;

  assign sel_idx = 32'(io_sel);

  // Source mux; an out-of-range index yields zero data and flags the beat.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (sel_idx == k) begin
        sel_data = io_srcs[k*XLEN +: XLEN];
        sel_err  = 1'b0;
      end
    end
  end

  // Writes to x0 and flagged beats never reach the register file.
  always_comb begin
    meta_in.rd      = io_rd;
    meta_in.wen     = io_wen & ~sel_err & (io_rd != '0);
    meta_in.sel_err = sel_err;
  end

  assign beat_in = {sel_data, meta_in};

  wb_select_pipe_skid #(
    .W (BeatW)
  ) u_skid (
    .clk_i       (clock),
    .rst_i       (reset),
    .in_valid_i  (io_in_valid),
    .in_ready_o  (io_in_ready),
    .in_data_i   (beat_in),
    .out_valid_o (io_out_valid),
    .out_ready_i (io_out_ready),
    .out_data_o  (beat_out)
  );

  assign {io_out_data, meta_out} = beat_out;
  assign io_out_rd  = meta_out.rd;
  assign io_out_wen = meta_out.wen;
  assign io_sel_err = meta_out.sel_err;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Scoreboard bench: four DUTs (NSRC = 2..5) share one handshake stream and run in lockstep.
module tb_wb_select_pipe;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic [2:0]        sel = '0;
  logic [4:0]        rd = '0;
  logic              wen = 1'b0;
  logic [4:0][31:0]  src_arr = '0;
  logic [159:0]      srcs_bus;

  logic [3:0]        in_ready_w, out_valid_w, out_wen_w, sel_err_w;
  logic [31:0]       out_data_w [4];
  logic [4:0]        out_rd_w [4];

  assign srcs_bus = src_arr;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int unsigned NS = gi + 2;
    wb_select_pipe #(
      .XLEN (32),
      .NSRC (NS),
      .SELW (3)
    ) u_dut (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (in_valid),
      .io_in_ready  (in_ready_w[gi]),
      .io_srcs      (srcs_bus[NS*32-1:0]),
      .io_sel       (sel),
      .io_rd        (rd),
      .io_wen       (wen),
      .io_out_valid (out_valid_w[gi]),
      .io_out_ready (out_ready),
      .io_out_data  (out_data_w[gi]),
      .io_out_rd    (out_rd_w[gi]),
      .io_out_wen   (out_wen_w[gi]),
      .io_sel_err   (sel_err_w[gi])
    );
  end

  // Expected write-back beat for every DUT variant (index i has NSRC = i+2).
  typedef struct packed {
    logic [3:0][31:0] data;
    logic [3:0]       wen;
    logic [3:0]       err;
    logic [4:0]       rd;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   accepted = 0;
  bit   mon_en = 1'b0;

  function automatic exp_t model(input logic [4:0][31:0] s, input logic [2:0] sl,
                                 input logic [4:0] r, input logic w);
    exp_t e;
    e.rd = r;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = i + 2;
      if (int'(sl) < n) begin
        e.data[i] = s[sl];
        e.err[i]  = 1'b0;
        e.wen[i]  = w && (r != 5'd0);
      end else begin
        e.data[i] = 32'd0;
        e.err[i]  = 1'b1;
        e.wen[i]  = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: record an accepted beat (or flush on reset), then land at posedge+1.
  task automatic step();
    @(negedge clock);
    #1;
    if (reset) begin
      q.delete();
    end else if (in_valid && in_ready_w[2]) begin
      q.push_back(model(src_arr, sel, rd, wen));
      accepted++;
    end
    @(posedge clock);
    #1;
  endtask

  // Monitor: occupancy implied by the queue, and head contents on every transfer out.
  initial begin
    exp_t e;
    bit   ev, er;
    forever begin
      @(negedge clock);
      if (mon_en && !reset) begin
        ev = (q.size() != 0);
        er = (q.size() < 2);
        for (int i = 0; i < 4; i++) begin
          check($sformatf("out_valid[%0d]", i), out_valid_w[i], ev);
          check($sformatf("in_ready[%0d]", i), in_ready_w[i], er);
        end
        if (ev && out_ready) begin
          e = q.pop_front();
          for (int i = 0; i < 4; i++) begin
            check($sformatf("data[%0d]", i), out_data_w[i], e.data[i]);
            check($sformatf("wen[%0d]", i), out_wen_w[i], e.wen[i]);
            check($sformatf("rd[%0d]", i), out_rd_w[i], e.rd);
            check($sformatf("sel_err[%0d]", i), sel_err_w[i], e.err[i]);
          end
        end
      end
    end
  end

  initial begin
    int start;
    int cyc;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid_w, 4'h0);
    check("rst_in_ready", in_ready_w, 4'hf);
    check("rst_out_data", out_data_w[2], 32'd0);
    check("rst_wen_err", {out_wen_w, sel_err_w}, 8'h0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Passthrough of each source, one-cycle latency.
    out_ready = 1'b1;
    wen = 1'b1;
    rd  = 5'd5;
    for (int k = 0; k < 5; k++) src_arr[k] = 32'h1000_0000 + k;
    for (int k = 0; k < 4; k++) begin
      sel = 3'(k);
      in_valid = 1'b1;
      step();
      check("pass_valid", out_valid_w[2], 1'b1);
      check("pass_data", out_data_w[2], 32'h1000_0000 + k);
      check("pass_wen", out_wen_w[2], 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("pass_idle", out_valid_w[2], 1'b0);

    // Stall: two beats fit, the third is refused, head stays put.
    out_ready = 1'b0;
    sel = 3'd1;
    for (int t = 0; t < 3; t++) begin
      src_arr[1] = 32'hA000_0000 + t;
      in_valid = 1'b1;
      step();
      check("stall_in_ready", in_ready_w[2], (t == 0));
      check("stall_head", out_data_w[2], 32'hA000_0000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("drain_in_ready", in_ready_w[2], 1'b1);
    check("drain_head", out_data_w[2], 32'hA000_0001);
    step();
    check("drain_idle", out_valid_w[2], 1'b0);

    // Simultaneous in/out while holding one beat.
    for (int t = 0; t < 5; t++) begin
      src_arr[1] = 32'hB000_0000 + t;
      in_valid = 1'b1;
      step();
      check("simul_head", out_data_w[2], 32'hB000_0000 + t);
      check("simul_in_ready", in_ready_w[2], 1'b1);
    end
    in_valid = 1'b0;
    step();

    // Out-of-range select on the NSRC=3 instance, then a legal beat.
    src_arr[3] = 32'hC0DE_0003;
    rd  = 5'd7;
    sel = 3'd3;
    in_valid = 1'b1;
    step();
    check("illegal_err", sel_err_w[1], 1'b1);
    check("illegal_data", out_data_w[1], 32'd0);
    check("illegal_wen", out_wen_w[1], 1'b0);
    check("legal4_data", out_data_w[2], 32'hC0DE_0003);
    sel = 3'd0;
    step();
    check("next_err", sel_err_w[1], 1'b0);
    check("next_wen", out_wen_w[1], 1'b1);
    in_valid = 1'b0;
    step();

    // Write to x0 passes data but drops wen.
    rd  = 5'd0;
    sel = 3'd1;
    src_arr[1] = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    step();
    check("x0_wen", out_wen_w[2], 1'b0);
    check("x0_data", out_data_w[2], 32'hDEAD_BEEF);
    in_valid = 1'b0;
    step();

    // Reset while full.
    rd = 5'd9;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    src_arr[1] = 32'hE000_0001;
    step();
    src_arr[1] = 32'hE000_0002;
    step();
    check("full_in_ready", in_ready_w[2], 1'b0);
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    check("mid_rst_valid", out_valid_w[2], 1'b0);
    check("mid_rst_ready", in_ready_w[2], 1'b1);
    check("mid_rst_data", out_data_w[2], 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (4) step();
    check("post_rst_idle", out_valid_w[2], 1'b0);

    // Random traffic with occasional reset.
    start = accepted;
    cyc = 0;
    while ((accepted - start) < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 999) == 0);
      sel = 3'($urandom_range(0, 7));
      rd  = 5'($urandom);
      wen = 1'($urandom);
      for (int k = 0; k < 5; k++) src_arr[k] = $urandom;
      step();
      cyc++;
    end
    check("rand_beats", ((accepted - start) >= 10000), 1'b1);

    reset = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    check("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
